sprite_row_fetcher: RTL and testbench

- Read-side initiator for the single-port 1024x8 sprite ROMs (wall, tank and similar tiles).
- On a start request it fetches one 32-pixel row of a 32x32 sprite from the ROM into a local line buffer, optionally mirrored horizontally.
- It then streams the row to the VGA line renderer over a valid/ready handshake, with a per-pixel transparency flag.
- It sits between the sprite ROM slave port and the renderer's line compositor.

---
 rtl/sprite_row_fetcher.sv | 134 +++++++++++++
 tb/tb_sprite_row_fetcher.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_row_fetcher.sv
// Fetches one row of a square sprite from a single-port synchronous ROM into a
// line buffer (optionally mirrored), then streams it out with a transparency flag.
module sprite_row_fetcher #(
  parameter int              SPRITE_W    = 32,
  parameter int              SPRITE_H    = 32,
  parameter int              ADDR_W      = 10,
  parameter int              DATA_W      = 8,
  parameter logic [DATA_W-1:0] TRANSPARENT = 8'hE3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [$clog2(SPRITE_H)-1:0] row,
  input  logic                        mirror,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_W-1:0]           rom_address,
  output logic                        rom_clken,
  input  logic [DATA_W-1:0]           rom_readdata,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic [DATA_W-1:0]           pix_data,
  output logic                        pix_opaque,
  output logic                        pix_last,
  output logic [1:0]                  fsm_state
);

  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);
  localparam logic [CW:0] K_DRAIN = (CW+1)'(SPRITE_W);
  localparam logic [CW:0] I_LAST  = (CW+1)'(SPRITE_W - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, STREAM = 2'd2} state_t;

  // Pixel output valid/ready: a pixel transfers on a cycle where pix_valid and
  // pix_ready are both high at the rising edge; while pix_valid is high and
  // pix_ready low, pix_data/pix_opaque/pix_last hold and pix_valid stays high.

  state_t              state;
  logic [RW-1:0]       row_q;
  logic                mirror_q;
  logic [CW:0]         k;
  logic [CW:0]         i;
  logic [CW:0]         k_next;
  logic [CW:0]         i_next;
  logic [CW:0]         wr_idx;
  logic [DATA_W-1:0]   line_buf [SPRITE_W];

  assign fsm_state = state;
  assign k_next    = k + 1'b1;
  assign i_next    = i + 1'b1;
  assign wr_idx    = k - 1'b1;

  // Mirroring reverses the column; for a power-of-two width that is a bitwise invert.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [RW-1:0] r,
                                                input logic m,
                                                input logic [CW-1:0] c);
    logic [CW-1:0] col;
    col = m ? ~c : c;
    return ADDR_W'({r, col});
  endfunction

  // Data for issue k-1 is on rom_readdata while k is presented (or during the drain).
  always_ff @(posedge clk) begin
    if (state == FETCH && k != '0)
      line_buf[wr_idx[CW-1:0]] <= rom_readdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      row_q       <= '0;
      mirror_q    <= 1'b0;
      k           <= '0;
      i           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rom_address <= '0;
      rom_clken   <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_opaque  <= 1'b0;
      pix_last    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= FETCH;
            row_q       <= row;
            mirror_q    <= mirror;
            k           <= '0;
            busy        <= 1'b1;
            rom_clken   <= 1'b1;
            rom_address <= addr_of(row, mirror, '0);
          end
        end
        FETCH: begin
          if (k == K_DRAIN) begin
            state      <= STREAM;
            rom_clken  <= 1'b0;
            i          <= '0;
            pix_valid  <= 1'b1;
            pix_data   <= line_buf[0];
            pix_opaque <= (line_buf[0] != TRANSPARENT);
            pix_last   <= (I_LAST == '0);
          end else begin
            k <= k_next;
            if (k_next != K_DRAIN)
              rom_address <= addr_of(row_q, mirror_q, k_next[CW-1:0]);
          end
        end
        STREAM: begin
          if (pix_ready) begin
            if (pix_last) begin
              state     <= IDLE;
              pix_valid <= 1'b0;
              pix_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              i          <= i_next;
              pix_data   <= line_buf[i_next[CW-1:0]];
              pix_opaque <= (line_buf[i_next[CW-1:0]] != TRANSPARENT);
              pix_last   <= (i_next == I_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Scoreboard bench for sprite_row_fetcher: ROM model, start driver, ready pattern
// driver, address/pixel queues checked on the falling edge.
module tb_sprite_row_fetcher;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [4:0] row;
  logic       mirror;
  logic       busy;
  logic       done;
  logic [9:0] rom_address;
  logic       rom_clken;
  logic [7:0] rom_readdata;
  logic       pix_valid;
  logic       pix_ready;
  logic [7:0] pix_data;
  logic       pix_opaque;
  logic       pix_last;
  logic [1:0] fsm_state;

  sprite_row_fetcher dut (
    .clk(clk), .reset_n(reset_n), .start(start), .row(row), .mirror(mirror),
    .busy(busy), .done(done), .rom_address(rom_address), .rom_clken(rom_clken),
    .rom_readdata(rom_readdata), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_opaque(pix_opaque), .pix_last(pix_last),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: registered read, one cycle latency
  logic [7:0] mem [1024];
  logic [7:0] rom_q;
  assign rom_readdata = rom_q;
  always @(posedge clk) if (rom_clken) rom_q <= mem[rom_address];

  // scoreboard state
  logic [9:0] exp_q  [$];
  logic [9:0] addr_q [$];
  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int first_valid_cyc = -1;
  int start_cyc = 0;
  int ready_mode = 0;
  bit stalled_prev = 0;
  bit valid_prev = 0;
  logic [9:0] held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ready pattern driver: 0 = always, 1 = 1,0,0,1 repeating, 2 = random
  initial begin
    int n;
    n = 0;
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        1: pix_ready = (n % 4 == 0) || (n % 4 == 3);
        2: pix_ready = 1'($urandom_range(0, 1));
        default: pix_ready = 1'b1;
      endcase
      n++;
    end
  end

  // monitor
  always @(negedge clk) begin
    if (!reset_n) begin
      stalled_prev = 0;
      valid_prev = 0;
    end else begin
      if (rom_clken) begin
        if (addr_q.size() == 0) chk("addr_unexpected", 32'(rom_address), 32'h3ff + 1);
        else chk("rom_address", 32'(rom_address), 32'(addr_q.pop_front()));
      end
      if (stalled_prev) begin
        chk("stall_valid", 32'(pix_valid), 1);
        chk("stall_hold", 32'({pix_last, pix_opaque, pix_data}), 32'(held));
      end
      if (pix_valid && !valid_prev) first_valid_cyc = cyc;
      if (pix_valid && pix_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("pix_unexpected", 1, 0);
        else chk("pixel", 32'({pix_last, pix_opaque, pix_data}), 32'(exp_q.pop_front()));
      end
      stalled_prev = pix_valid && !pix_ready;
      held = {pix_last, pix_opaque, pix_data};
      valid_prev = pix_valid;
      if (done) done_cnt++;
    end
  end

  // driver tasks
  task automatic push_row(input int r, input bit m);
    int a;
    logic [7:0] d;
    for (int k = 0; k < 32; k++) begin
      a = r * 32 + (m ? 31 - k : k);
      d = mem[a];
      addr_q.push_back(a[9:0]);
      exp_q.push_back({k == 31, d != 8'hE3, d});
    end
    addr_q.push_back(a[9:0]);
    exp_done++;
  endtask

  // Drives start in the current (post-negedge) cycle, then drops it.
  task automatic do_start(input int r, input bit m);
    start = 1'b1;
    row = 5'(r);
    mirror = m;
    push_row(r, m);
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    row = 5'(($urandom_range(0, 31)));
    mirror = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int dcyc);
    int n;
    n = 0;
    dcyc = -1;
    while (n < 400) begin
      @(negedge clk);
      if (done) begin
        dcyc = cyc;
        break;
      end
      n++;
    end
    if (dcyc < 0) chk("done_timeout", 0, 1);
    chk("queue_drained", 32'(exp_q.size() + addr_q.size()), 0);
  endtask

  initial begin
    int dcyc;
    int base;
    int prev_done;
    for (int a = 0; a < 1024; a++) mem[a] = 8'(a);
    mem[165] = 8'hE3;
    start = 1'b0; row = '0; mirror = 1'b0;
    reset_n = 1'b0;
    #23;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_clken", 32'(rom_clken), 0);
    chk("rst_addr", 32'(rom_address), 0);
    chk("rst_data", 32'({pix_last, pix_opaque, pix_data}), 0);
    chk("rst_state", 32'(fsm_state), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // row 0, plain, ready held high: latency and total time
    ready_mode = 0;
    first_valid_cyc = -1;
    do_start(0, 0);
    chk("busy_after_accept", 32'(busy), 1);
    wait_done(dcyc);
    chk("first_valid_latency", 32'(first_valid_cyc - start_cyc), 34);
    chk("start_to_done", 32'(dcyc - start_cyc), 66);
    chk("busy_in_done", 32'(busy), 0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);

    // row 5 mirrored
    do_start(5, 1);
    wait_done(dcyc);
    @(negedge clk);

    // row 5 with transparent pixel, ready stalling 1,0,0,1
    ready_mode = 1;
    do_start(5, 0);
    wait_done(dcyc);
    @(negedge clk);

    // random ready; start during FETCH ignored; start in done cycle accepted
    ready_mode = 2;
    do_start(3, 0);
    repeat (9) @(negedge clk);
    start = 1'b1; row = 5'd7; mirror = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(dcyc);
    do_start(9, 1);
    chk("restart_busy", 32'(busy), 1);
    wait_done(dcyc);
    @(negedge clk);

    // reset during STREAM after 12 handshakes
    ready_mode = 0;
    prev_done = done_cnt;
    base = hs_cnt;
    do_start(12, 0);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      if (hs_cnt - base >= 12) break;
    end
    chk("hs_before_reset", 32'(hs_cnt - base), 12);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_valid", 32'(pix_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_clken", 32'(rom_clken), 0);
    chk("abort_state", 32'(fsm_state), 0);
    exp_q.delete();
    addr_q.delete();
    exp_done--;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(prev_done));
    do_start(31, 1);
    wait_done(dcyc);
    repeat (3) @(negedge clk);

    chk("done_count", 32'(done_cnt), 32'(exp_done));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
